approx_add_recover_16: RTL and testbench



---
 rtl/approx_add_recover_16_pkg.sv | 12 +
 rtl/approx_add_recover_16_approx_cla_win.sv | 53 +++++
 rtl/approx_add_recover_16.sv | 141 ++++++++++++++
 tb/tb_approx_add_recover_16.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_add_recover_16_pkg.sv
// rtl/approx_add_recover_16_pkg.sv - shared constants for the windowed-carry adder recovery block
package approx_add_recover_16_pkg;

    localparam int ADD_W     = 16;
    localparam int CARRY_WIN = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EVAL = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

endpackage

// File: rtl/approx_add_recover_16_approx_cla_win.sv
// rtl/approx_add_recover_16_approx_cla_win.sv - combinational windowed-carry adder with exact reference and error compare
module approx_cla_win
    import approx_add_recover_16_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             cin,
    output logic [ADD_W-1:0] approx_sum,
    output logic             approx_cout,
    output logic [ADD_W-1:0] exact_sum,
    output logic             exact_cout,
    output logic             err
);

    logic [ADD_W-1:0] p;
    logic [ADD_W-1:0] g;
    logic [ADD_W:0]   c;

    assign p    = a ^ b;
    assign g    = a & b;
    assign c[0] = cin;

    // Low carries are exact; from CARRY_WIN upward each carry only sees the
    // CARRY_WIN bit positions directly below it, with no cin term.
    genvar i, k;
    generate
        for (i = 1; i <= ADD_W; i++) begin : g_carry
            if (i < CARRY_WIN) begin : g_exact
                assign c[i] = g[i-1] | (p[i-1] & c[i-1]);
            end else begin : g_win
                logic [CARRY_WIN:0]   acc;
                logic [CARRY_WIN-1:0] run;
                assign acc[0] = 1'b0;
                assign run[0] = 1'b1;
                for (k = 1; k <= CARRY_WIN; k++) begin : g_term
                    assign acc[k] = acc[k-1] | (run[k-1] & g[i-k]);
                    if (k < CARRY_WIN) begin : g_run
                        assign run[k] = run[k-1] & p[i-k];
                    end
                end
                assign c[i] = acc[CARRY_WIN];
            end
        end
    endgenerate

    assign approx_sum  = p ^ c[ADD_W-1:0];
    assign approx_cout = c[ADD_W];

    assign {exact_cout, exact_sum} = {1'b0, a} + {1'b0, b} + {{ADD_W{1'b0}}, cin};

    assign err = {approx_cout, approx_sum} != {exact_cout, exact_sum};

endmodule

// File: rtl/approx_add_recover_16.sv
// rtl/approx_add_recover_16.sv - handshaked approximate adder with error detection, optional exact repair and statistics
module approx_add_recover_16
    import approx_add_recover_16_pkg::*;
#(
    parameter logic EXACT_EN = 1'b1,
    parameter int   CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ADD_W-1:0] sum,
    output logic             cout,
    output logic             err_flag,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] op_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    logic [1:0]       state_q, state_d;
    logic [ADD_W-1:0] a_q, a_d;
    logic [ADD_W-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    logic [ADD_W-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [ADD_W-1:0] approx_sum;
    logic             approx_cout;
    logic [ADD_W-1:0] exact_sum;
    logic             exact_cout;
    logic             add_err;
    logic             accept;
    logic             out_hs;

    approx_cla_win u_cla (
        .a           (a_q),
        .b           (b_q),
        .cin         (cin_q),
        .approx_sum  (approx_sum),
        .approx_cout (approx_cout),
        .exact_sum   (exact_sum),
        .exact_cout  (exact_cout),
        .err         (add_err)
    );

    assign out_valid = (state_q == DONE);
    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;

        if (accept) begin
            a_d   = a;
            b_d   = b;
            cin_d = cin;
        end

        case (state_q)
            IDLE: if (accept) state_d = EVAL;
            EVAL: begin
                if (add_err && EXACT_EN) begin
                    state_d = FIX;
                end else begin
                    sum_d   = approx_sum;
                    cout_d  = approx_cout;
                    err_d   = add_err;
                    state_d = DONE;
                end
            end
            FIX: begin
                sum_d   = exact_sum;
                cout_d  = exact_cout;
                err_d   = 1'b1;
                state_d = DONE;
            end
            default: begin
                if (out_ready) state_d = accept ? EVAL : IDLE;
            end
        endcase
    end

    // Counters saturate rather than wrap so long hardware runs never under-report.
    always_comb begin
        op_cnt_d  = op_cnt_q;
        err_cnt_d = err_cnt_q;
        if (clr_cnt) begin
            op_cnt_d  = '0;
            err_cnt_d = '0;
        end else if (out_hs) begin
            if (op_cnt_q != '1) op_cnt_d = op_cnt_q + CNT_W'(1);
            if (err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            cin_q     <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            err_q     <= 1'b0;
            op_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cin_q     <= cin_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            err_q     <= err_d;
            op_cnt_q  <= op_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign err_flag = err_q;
    assign op_cnt   = op_cnt_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_approx_add_recover_16.sv
// tb/tb_approx_add_recover_16.sv - directed self-checking bench for approx_add_recover_16
module tb_approx_add_recover_16;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_cnt;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        iv   [3];
    logic        ordy [3];

    logic [15:0] sum_w [3];
    logic        cout_w [3];
    logic        err_w [3];
    logic        ov_w [3];
    logic        ir_w [3];
    logic [15:0] opc0, erc0, opc1, erc1;
    logic [1:0]  opc2, erc2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // instance 0: repair on, instance 1: approximate only, instance 2: 2-bit counters
    approx_add_recover_16 #(.EXACT_EN(1'b1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
        .in_valid(iv[0]), .in_ready(ir_w[0]), .sum(sum_w[0]), .cout(cout_w[0]),
        .err_flag(err_w[0]), .out_valid(ov_w[0]), .out_ready(ordy[0]),
        .clr_cnt(clr_cnt), .op_cnt(opc0), .err_cnt(erc0)
    );

    approx_add_recover_16 #(.EXACT_EN(1'b0), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
        .in_valid(iv[1]), .in_ready(ir_w[1]), .sum(sum_w[1]), .cout(cout_w[1]),
        .err_flag(err_w[1]), .out_valid(ov_w[1]), .out_ready(ordy[1]),
        .clr_cnt(clr_cnt), .op_cnt(opc1), .err_cnt(erc1)
    );

    approx_add_recover_16 #(.EXACT_EN(1'b1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
        .in_valid(iv[2]), .in_ready(ir_w[2]), .sum(sum_w[2]), .cout(cout_w[2]),
        .err_flag(err_w[2]), .out_valid(ov_w[2]), .out_ready(ordy[2]),
        .clr_cnt(clr_cnt), .op_cnt(opc2), .err_cnt(erc2)
    );

    // Latency counts rising edges from the accepting edge up to out_valid high.
    task automatic run_op(input int idx, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tc, output int lat);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; iv[idx] = 1'b1; ordy[idx] = 1'b0;
        #1;
        checks++;
        if (ir_w[idx] !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready dut%0d got=%b exp=1", idx, ir_w[idx]);
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        iv[idx] = 1'b0;
        while (ov_w[idx] !== 1'b1 && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic finish_hs(input int idx);
        ordy[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[idx] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; clr_cnt = 1'b0; a = 16'hFFFF; b = 16'h0001; cin = 1'b0;
        for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; ordy[i] = 1'b0; end
        iv[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; iv[0] = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ir_w[i] !== 1'b1 || ov_w[i] !== 1'b0 || sum_w[i] !== 16'h0 ||
                cout_w[i] !== 1'b0 || err_w[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d got ir=%b ov=%b sum=%h cout=%b err=%b exp ir=1 ov=0 sum=0000 cout=0 err=0",
                         i, ir_w[i], ov_w[i], sum_w[i], cout_w[i], err_w[i]);
            end
        end
        checks++;
        if (opc0 !== 16'd0 || erc0 !== 16'd0 || opc2 !== 2'd0 || erc2 !== 2'd0) begin
            failures++;
            $display("FAIL reset_counters got %0d/%0d %0d/%0d exp 0/0 0/0", opc0, erc0, opc2, erc2);
        end
        @(negedge clk);
        checks++;
        if (ov_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_ignores_input got ov=%b exp=0", ov_w[0]);
        end
    endtask

    task automatic test_clean;
        int lat;
        run_op(0, 16'h000F, 16'h0001, 1'b0, lat);
        checks++;
        if (lat !== 2 || sum_w[0] !== 16'h0010 || cout_w[0] !== 1'b0 || err_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL clean_op got lat=%0d sum=%h cout=%b err=%b exp lat=2 sum=0010 cout=0 err=0",
                     lat, sum_w[0], cout_w[0], err_w[0]);
        end
        finish_hs(0);
        checks++;
        if (opc0 !== 16'd1 || erc0 !== 16'd0 || ov_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL clean_counts got op=%0d err=%0d ov=%b exp op=1 err=0 ov=0", opc0, erc0, ov_w[0]);
        end
    endtask

    task automatic test_fix;
        int lat;
        run_op(0, 16'h00FF, 16'h0001, 1'b0, lat);
        checks++;
        if (lat !== 3 || sum_w[0] !== 16'h0100 || cout_w[0] !== 1'b0 || err_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL fix_op got lat=%0d sum=%h cout=%b err=%b exp lat=3 sum=0100 cout=0 err=1",
                     lat, sum_w[0], cout_w[0], err_w[0]);
        end
        finish_hs(0);
        checks++;
        if (opc0 !== 16'd2 || erc0 !== 16'd1) begin
            failures++;
            $display("FAIL fix_counts got op=%0d err=%0d exp op=2 err=1", opc0, erc0);
        end
    endtask

    task automatic test_approx_only;
        int lat;
        run_op(1, 16'h00FF, 16'h0001, 1'b0, lat);
        checks++;
        if (lat !== 2 || sum_w[1] !== 16'h00E0 || cout_w[1] !== 1'b0 || err_w[1] !== 1'b1) begin
            failures++;
            $display("FAIL approx_only got lat=%0d sum=%h cout=%b err=%b exp lat=2 sum=00e0 cout=0 err=1",
                     lat, sum_w[1], cout_w[1], err_w[1]);
        end
        finish_hs(1);
        checks++;
        if (opc1 !== 16'd1 || erc1 !== 16'd1) begin
            failures++;
            $display("FAIL approx_counts got op=%0d err=%0d exp op=1 err=1", opc1, erc1);
        end
    endtask

    task automatic test_cin_cout;
        int lat;
        run_op(0, 16'h000F, 16'h0000, 1'b1, lat);
        checks++;
        if (lat !== 3 || sum_w[0] !== 16'h0010 || cout_w[0] !== 1'b0 || err_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL cin_window got lat=%0d sum=%h cout=%b err=%b exp lat=3 sum=0010 cout=0 err=1",
                     lat, sum_w[0], cout_w[0], err_w[0]);
        end
        finish_hs(0);
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, lat);
        checks++;
        if (lat !== 3 || sum_w[0] !== 16'h0000 || cout_w[0] !== 1'b1 || err_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL cout_error got lat=%0d sum=%h cout=%b err=%b exp lat=3 sum=0000 cout=1 err=1",
                     lat, sum_w[0], cout_w[0], err_w[0]);
        end
        finish_hs(0);
        checks++;
        if (opc0 !== 16'd4 || erc0 !== 16'd3) begin
            failures++;
            $display("FAIL cin_cout_counts got op=%0d err=%0d exp op=4 err=3", opc0, erc0);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        run_op(0, 16'h1234, 16'h0001, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ov_w[0] !== 1'b1 || sum_w[0] !== 16'h1235 || err_w[0] !== 1'b0 || ir_w[0] !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cycle=%0d got ov=%b sum=%h err=%b ir=%b exp ov=1 sum=1235 err=0 ir=0",
                         i, ov_w[0], sum_w[0], err_w[0], ir_w[0]);
            end
            @(negedge clk);
        end
        a = 16'h000F; b = 16'h0001; cin = 1'b0; iv[0] = 1'b1; ordy[0] = 1'b1;
        #1;
        checks++;
        if (ir_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready got=%b exp=1", ir_w[0]);
        end
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0; ordy[0] = 1'b0;
        checks++;
        if (ov_w[0] !== 1'b0 || ir_w[0] !== 1'b0 || opc0 !== 16'd5) begin
            failures++;
            $display("FAIL b2b_eval got ov=%b ir=%b op=%0d exp ov=0 ir=0 op=5", ov_w[0], ir_w[0], opc0);
        end
        @(negedge clk);
        checks++;
        if (ov_w[0] !== 1'b1 || sum_w[0] !== 16'h0010 || err_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_result got ov=%b sum=%h err=%b exp ov=1 sum=0010 err=0", ov_w[0], sum_w[0], err_w[0]);
        end
        finish_hs(0);
        checks++;
        if (opc0 !== 16'd6 || erc0 !== 16'd3) begin
            failures++;
            $display("FAIL b2b_counts got op=%0d err=%0d exp op=6 err=3", opc0, erc0);
        end
    endtask

    task automatic test_clr_cnt;
        int lat;
        run_op(0, 16'h00FF, 16'h0001, 1'b0, lat);
        clr_cnt = 1'b1;
        finish_hs(0);
        clr_cnt = 1'b0;
        checks++;
        if (opc0 !== 16'd0 || erc0 !== 16'd0 || opc1 !== 16'd0 || erc1 !== 16'd0) begin
            failures++;
            $display("FAIL clr_priority got %0d/%0d %0d/%0d exp 0/0 0/0", opc0, erc0, opc1, erc1);
        end
    endtask

    task automatic test_saturation;
        int lat;
        int exp_n;
        for (int n = 1; n <= 5; n++) begin
            run_op(2, 16'h00FF, 16'h0001, 1'b0, lat);
            finish_hs(2);
            exp_n = (n > 3) ? 3 : n;
            checks++;
            if (opc2 !== 2'(exp_n) || erc2 !== 2'(exp_n)) begin
                failures++;
                $display("FAIL saturation op#%0d got op=%0d err=%0d exp op=%0d err=%0d", n, opc2, erc2, exp_n, exp_n);
            end
        end
    endtask

    task automatic test_reset_in_fix;
        int lat;
        run_op(0, 16'h000F, 16'h0001, 1'b0, lat);
        finish_hs(0);
        checks++;
        if (opc0 !== 16'd1) begin
            failures++;
            $display("FAIL pre_reset_count got op=%0d exp 1", opc0);
        end
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ov_w[0] !== 1'b0 || ir_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL in_fix got ov=%b ir=%b exp ov=0 ir=0", ov_w[0], ir_w[0]);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ov_w[0] !== 1'b0 || ir_w[0] !== 1'b1 || opc0 !== 16'd0 || erc0 !== 16'd0 || sum_w[0] !== 16'h0) begin
            failures++;
            $display("FAIL reset_in_fix got ov=%b ir=%b op=%0d err=%0d sum=%h exp ov=0 ir=1 op=0 err=0 sum=0000",
                     ov_w[0], ir_w[0], opc0, erc0, sum_w[0]);
        end
        @(negedge clk);
        checks++;
        if (ov_w[0] !== 1'b0 || opc0 !== 16'd0) begin
            failures++;
            $display("FAIL post_reset_idle got ov=%b op=%0d exp ov=0 op=0", ov_w[0], opc0);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_fix();
        test_approx_only();
        test_cin_cout();
        test_back_to_back();
        test_clr_cnt();
        test_saturation();
        test_reset_in_fix();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
